ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
Sequencer between the PS/2 frame receiver (validated scan-code bytes) and downstream consumers (seg display, ASCII LUT, software-visible counters).
- Parses make, break (F0) and extended (E0) prefix sequences into single key events.
- Queues events in a small FIFO behind a valid/ready handshake.
- Maintains the held-key state and a release counter.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, at least 2.
- TIMEOUT_CYC, 2_000_000, max clk cycles allowed between prefix byte and its follow-up byte before the sequence is abandoned.
- CNT_W, 16, width of press_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle pulse: code_data holds a parity/start/stop-checked byte.
- code_data  in  8  scan-code byte.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pops head when evt_valid and evt_ready are both high.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event is extended (E0).
- evt_brk  out  1  head event is a release.
- key_held  out  1  a key is currently down.
- held_code  out  9  {ext, code} of the most recent accepted make.
- press_cnt  out  CNT_W  count of accepted break events; wraps.
- seq_err  out  1  one-cycle pulse on prefix protocol error or timeout.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf; set has priority if both occur in the same cycle.

Behaviour:
- Reset: every output 0; FIFO empty; FSM in IDLE; timer 0.
- FSM states: IDLE, PEND_E0, PEND_F0, PEND_E0F0. Transitions happen only on code_valid.
  - IDLE: E0 -> PEND_E0; F0 -> PEND_F0; any other byte -> emit make {ext=0}.
  - PEND_E0: F0 -> PEND_E0F0; E0 -> stay, no error; other byte -> emit make {ext=1}, go to IDLE.
  - PEND_F0: other byte -> emit break {ext=0}, go to IDLE. An E0 or F0 here pulses seq_err and is re-processed as if received in IDLE.
  - PEND_E0F0: other byte -> emit break {ext=1}, go to IDLE. An E0 or F0 here pulses seq_err and is re-processed as in IDLE.
- Timeout:
  - The timer counts while in a PEND state and resets on every code_valid.
  - When the timer reaches TIMEOUT_CYC-1, the FSM returns to IDLE and seq_err pulses.
  - If the timeout cycle coincides with code_valid, the byte wins and no timeout occurs.
- Emit:
  - The event word {ext, brk, code} is pushed into the FIFO.
  - evt_valid rises the cycle after the code_valid cycle that completed the sequence (1-cycle latency).
- Make events: set key_held=1 and load held_code.
- Break events: increment press_cnt (modulo 2^CNT_W). If {ext, code} equals held_code, clear key_held; otherwise key_held is unchanged.
- Counters and key_held update whether or not the FIFO accepts the event.
- FIFO:
  - Head is registered on evt_code/evt_ext/evt_brk. Outputs hold stable while evt_valid=1 and evt_ready=0.
  - Full and push with no pop: event dropped, ovf set.
  - Full with push and pop in the same cycle: both accepted, count unchanged.
  - Empty: evt_ready ignored.
  - Pointers wrap at FIFO_DEPTH.
- Reset mid-sequence: any pending prefix is discarded; a byte arriving later in IDLE is handled per the IDLE rules.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined: a make whose {ext, code} equals held_code while key_held=1 (typematic repeat) is not pushed and does not change state.
- Undefined: every make is pushed, including repeats.
- Break handling and press_cnt are identical in both builds.

Decomposition:
- Package ps2_pkg:
  - PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0.
  - FSM state enum.
  - ps2_evt_t struct {ext, brk, code[7:0]} with EVT_W=10.
- One sub-module: ps2_evt_fifo. Parameterised synchronous FIFO of EVT_W bits, with push/pop/full/empty and same-cycle push/pop when full. The FSM, timer and counters stay in the top module.

Test Plan:
- Bytes 1C; F0 1C -> events {0,0,1C} then {0,1,1C}; press_cnt=1; key_held 1 then 0; evt_valid high 1 cycle after each final byte.
- Bytes E0 75; E0 F0 75 -> events {1,0,75}, {1,1,75}; held_code=9'h175 then key_held=0.
- Bytes F0 then no byte for TIMEOUT_CYC cycles -> seq_err pulse, state IDLE; next byte 1C -> make {0,0,1C}.
- Bytes F0 E0 74 -> seq_err on E0; event {1,0,74}.
- evt_ready=0, push FIFO_DEPTH+1 makes -> FIFO_DEPTH entries, ovf=1. Then push and pop in the same cycle while full -> both succeed. ovf_clr -> ovf=0.
- Bytes 1C 1C 1C -> 3 make events without PS2_REPEAT_FILTER_EN, 1 with it. Assert rst between E0 and 75 -> 75 emits {0,0,75}.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants, FSM state codes and event word for the PS/2
//            key event sequencer.
// Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE     = 2'd0;
  localparam ps2_state_t ST_PEND_E0  = 2'd1;
  localparam ps2_state_t ST_PEND_F0  = 2'd2;
  localparam ps2_state_t ST_PEND_E0F0 = 2'd3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int EVT_W = $bits(ps2_evt_t);

  function automatic ps2_evt_t mk_evt(input logic ext, input logic brk,
                                      input logic [7:0] code);
    ps2_evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_evt_fifo
// Purpose  : Synchronous event FIFO; a push into a full FIFO is accepted when
//            a pop happens in the same cycle, otherwise it is dropped.
// Revision : 1.0  initial release
// ============================================================================
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [AW:0]   c_cnt_one = (AW + 1)'(1);
  localparam logic [AW:0]   c_cnt_max = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == c_cnt_max);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign drop      = push && !w_do_push;
  assign dout      = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + c_ptr_one;
      if (w_do_pop)  r_rd <= r_rd + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + c_cnt_one;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_ctrl
// Purpose  : Turns PS/2 scan-code bytes (E0/F0 prefixes) into key events,
//            queues them and tracks held key / release count.
//            Build option PS2_REPEAT_FILTER_EN drops typematic repeat makes.
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [7:0]       code_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             key_held,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             seq_err,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] c_tmo_last = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] c_tmr_one  = TMR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  ps2_state_t       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_key_held;
  logic [8:0]       r_held_code;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_seq_err;
  logic             r_ovf;

  ps2_state_t w_next_state;
  logic       w_is_ext;
  logic       w_is_brk;
  logic       w_emit;
  logic       w_err;
  logic       w_repeat;
  logic       w_push;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  ps2_evt_t   w_evt;
  ps2_evt_t   w_head;

  assign w_is_ext = (code_data == PS2_PFX_EXT);
  assign w_is_brk = (code_data == PS2_PFX_BRK);

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    w_evt        = mk_evt(1'b0, 1'b0, code_data);
    if (code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_ext)      w_next_state = ST_PEND_E0;
          else if (w_is_brk) w_next_state = ST_PEND_F0;
          else               w_emit       = 1'b1;
        end
        ST_PEND_E0: begin
          if (w_is_brk) w_next_state = ST_PEND_E0F0;
          else if (!w_is_ext) begin
            w_emit       = 1'b1;
            w_evt        = mk_evt(1'b1, 1'b0, code_data);
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          // A prefix after F0 is a protocol error, then handled as from IDLE.
          if (w_is_ext || w_is_brk) begin
            w_err        = 1'b1;
            w_next_state = w_is_ext ? ST_PEND_E0 : ST_PEND_F0;
          end else begin
            w_emit       = 1'b1;
            w_evt        = mk_evt(r_state == ST_PEND_E0F0, 1'b1, code_data);
            w_next_state = ST_IDLE;
          end
        end
      endcase
    end else if (r_state != ST_IDLE && r_tmr == c_tmo_last) begin
      w_err        = 1'b1;
      w_next_state = ST_IDLE;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  assign w_repeat = !w_evt.brk && r_key_held &&
                    ({w_evt.ext, w_evt.code} == r_held_code);
`else
  assign w_repeat = 1'b0;
`endif

  assign w_push = w_emit && !w_repeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_key_held  <= 1'b0;
      r_held_code <= '0;
      r_press_cnt <= '0;
      r_seq_err   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tmr     <= (code_valid || w_next_state == ST_IDLE) ? '0 : r_tmr + c_tmr_one;
      r_seq_err <= w_err;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      if (w_push) begin
        if (w_evt.brk) begin
          r_press_cnt <= r_press_cnt + c_cnt_one;
          if ({w_evt.ext, w_evt.code} == r_held_code) r_key_held <= 1'b0;
        end else begin
          r_key_held  <= 1'b1;
          r_held_code <= {w_evt.ext, w_evt.code};
        end
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_evt),
    .pop   (evt_ready),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .drop  (w_drop)
  );

  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_brk   = w_head.brk;
  assign key_held  = r_key_held;
  assign held_code = r_held_code;
  assign press_cnt = r_press_cnt;
  assign seq_err   = r_seq_err;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_ctrl
// Purpose  : Scoreboard bench for ps2_key_event_ctrl with a prefix-flag model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          code_valid = 1'b0;
  logic [7:0]    code_data = 8'h00;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_brk;
  logic          key_held;
  logic [8:0]    held_code;
  logic [CW-1:0] press_cnt;
  logic          seq_err;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  always #5 clk = ~clk;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_data  (code_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_brk    (evt_brk),
    .key_held   (key_held),
    .held_code  (held_code),
    .press_cnt  (press_cnt),
    .seq_err    (seq_err),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending prefixes are two flags, the FIFO is a queue.
  bit            m_ext, m_brk, m_held, m_ovf, m_err, m_drop;
  int            m_idle;
  logic [8:0]    m_code;
  logic [CW-1:0] m_cnt;
  logic [9:0]    q[$];

  function automatic void m_push(input logic [9:0] w);
    if (q.size() < DEPTH) q.push_back(w);
    else m_drop = 1'b1;
  endfunction

  function automatic void m_emit(input bit ext, input bit brk, input logic [7:0] c);
    if (brk) begin
      m_cnt = m_cnt + 1'b1;
      if ({ext, c} == m_code) m_held = 1'b0;
      m_push({ext, brk, c});
    end else begin
`ifdef PS2_REPEAT_FILTER_EN
      if (m_held && {ext, c} == m_code) return;
`endif
      m_held = 1'b1;
      m_code = {ext, c};
      m_push({ext, brk, c});
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ext = 0; m_brk = 0; m_held = 0; m_ovf = 0; m_err = 0; m_drop = 0;
      m_idle = 0; m_code = '0; m_cnt = '0;
      q.delete();
    end else begin
      m_err  = 0;
      m_drop = 0;
      if (code_valid) begin
        m_idle = 0;
        if (code_data == 8'hE0) begin
          if (m_brk) begin m_err = 1; m_brk = 0; end
          m_ext = 1;
        end else if (code_data == 8'hF0) begin
          if (m_brk) begin m_err = 1; m_ext = 0; end
          m_brk = 1;
        end else begin
          m_emit(m_ext, m_brk, code_data);
          m_ext = 0;
          m_brk = 0;
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_err = 1; m_ext = 0; m_brk = 0; m_idle = 0;
        end
      end
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  // Monitor: compares the presented head and status every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("evt_word", 32'({evt_ext, evt_brk, evt_code}), 32'(q[0]));
        if (evt_ready) void'(q.pop_front());
      end
      check("key_held", 32'(key_held), 32'(m_held));
      check("held_code", 32'(held_code), 32'(m_code));
      check("press_cnt", 32'(press_cnt), 32'(m_cnt));
      check("seq_err", 32'(seq_err), 32'(m_err));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  bit ready_rand = 0;
  bit ready_force = 0;
  always @(posedge clk) begin
    #1;
    evt_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    code_valid = 1'b1;
    code_data  = b;
    @(posedge clk); #1;
    code_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    ready_rand  = 0;
    ready_force = 1;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    check("drain_bound", 32'(q.size()), 32'd0);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] pool [4] = '{8'h1C, 8'h75, 8'h74, 8'h2B};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_word", 32'({evt_ext, evt_brk, evt_code}), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_held_code", 32'(held_code), 32'd0);
    check("rst_press_cnt", 32'(press_cnt), 32'd0);
    check("rst_seq_err_ovf", 32'({seq_err, ovf}), 32'd0);

    ready_force = 1;
    send(8'h1C, 2); send(8'hF0, 0); send(8'h1C, 2);
    send(8'hE0, 0); send(8'h75, 2);
    check("held_code_ext", 32'(held_code), 32'h175);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
    check("ext_release", 32'(key_held), 32'd0);
    send(8'hF0, TMO + 3);
    send(8'h1C, 2);
    send(8'hF0, 0); send(8'hE0, 0); send(8'h74, 2);
    send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 2);
    drain();

    ready_force = 0;
    @(posedge clk);
    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 0);
    @(negedge clk);
    check("ovf_after_overflow", 32'(ovf), 32'd1);
    check("full_valid", 32'(evt_valid), 32'd1);
    ready_force = 1;
    send(8'h30, 0);
    ready_force = 0;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(ovf), 32'd0);
    drain();

    send(8'hE0, 0);
    do_reset();
    send(8'h75, 2);
    drain();

    ready_rand = 1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      int gap;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : pool[$urandom_range(0, 3)];
      gap = ($urandom_range(0, 39) == 0) ? TMO - 3 + $urandom_range(0, 4)
                                          : $urandom_range(0, 2);
      ovf_clr = ($urandom_range(0, 7) == 0);
      send(b, gap);
      ovf_clr = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
